// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : THCO-MIPS MEM stage. It forwards write-back data and runs
//               load/store accesses as request/acknowledge bus transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead_i,
    input  logic                  memWrite_i,
    input  logic [ADDR_W-1:0]     memAddr_i,
    input  logic [DATA_W-1:0]     memWData_i,
    input  logic [DATA_W-1:0]     wData_i,
    input  logic                  wReg_i,
    input  logic [REG_ADDR_W-1:0] wRegAddr_i,
    output logic                  busReq_o,
    output logic                  busWe_o,
    output logic [ADDR_W-1:0]     busAddr_o,
    output logic [DATA_W-1:0]     busWData_o,
    input  logic [DATA_W-1:0]     busRData_i,
    input  logic                  busAck_i,
    output logic [DATA_W-1:0]     wData_o,
    output logic                  wReg_o,
    output logic [REG_ADDR_W-1:0] wRegAddr_o,
    output logic                  stallReq_o,
    output logic                  memErr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t            r_state;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_cnt;
    logic              r_err;

    logic w_acc;
    logic w_stall;
    logic [7:0] w_cnt_next;

    assign w_acc      = memRead_i | memWrite_i;
    assign w_stall    = ((r_state == S_IDLE) & w_acc) | (r_state == S_WAIT);
    assign w_cnt_next = r_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            busReq_o   <= 1'b0;
            busWe_o    <= 1'b0;
            busAddr_o  <= '0;
            busWData_o <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        // Store wins when both read and write are requested.
                        busAddr_o  <= memAddr_i;
                        busWData_o <= memWData_i;
                        busWe_o    <= memWrite_i;
                        busReq_o   <= 1'b1;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (busAck_i) begin
                        if (!busWe_o) begin
                            r_rdata <= busRData_i;
                        end
                        busReq_o <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == c_timeout) begin
                            busReq_o <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Only bubbles reach WB while stalled; a timed-out access never writes back.
    always_comb begin
        wReg_o  = wReg_i;
        wData_o = wData_i;
        if (w_stall) begin
            wReg_o = 1'b0;
        end else if (r_state == S_DONE) begin
            wReg_o = wReg_i & ~r_err;
            if (!busWe_o) begin
                wData_o = r_rdata;
            end
        end
    end

    assign stallReq_o = w_stall;
    assign wRegAddr_o = wRegAddr_i;
    assign memErr_o   = (r_state == S_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access against a per-instruction
//               latency/outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead_i, memWrite_i;
    logic [15:0] memAddr_i, memWData_i, wData_i;
    logic        wReg_i;
    logic [3:0]  wRegAddr_i;
    logic        busReq_o, busWe_o;
    logic [15:0] busAddr_o, busWData_o, busRData_i;
    logic        busAck_i;
    logic [15:0] wData_o;
    logic        wReg_o;
    logic [3:0]  wRegAddr_o;
    logic        stallReq_o, memErr_o;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] rdata_m;

    mem_access #(
        .DATA_W(16), .ADDR_W(16), .REG_ADDR_W(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i),
        .memAddr_i(memAddr_i), .memWData_i(memWData_i),
        .wData_i(wData_i), .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i),
        .busReq_o(busReq_o), .busWe_o(busWe_o),
        .busAddr_o(busAddr_o), .busWData_o(busWData_o),
        .busRData_i(busRData_i), .busAck_i(busAck_i),
        .wData_o(wData_o), .wReg_o(wReg_o), .wRegAddr_o(wRegAddr_o),
        .stallReq_o(stallReq_o), .memErr_o(memErr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction. k = WAIT cycle carrying the ack (1..TO), 0 = never acked.
    // Access takes k+2 cycles (TO+2 on timeout); a non-access takes 1 cycle.
    task automatic run_instr(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdat, input logic [15:0] wd,
                             input logic wre, input logic [3:0] wra,
                             input int k, input logic [15:0] rdv);
        logic acc, err, readop, done, stall_e, req_e;
        int   len;
        acc    = rd | wr;
        err    = acc && (k == 0);
        readop = rd & ~wr;
        len    = !acc ? 1 : ((k == 0) ? TO : k) + 2;
        memRead_i  = rd;
        memWrite_i = wr;
        memAddr_i  = addr;
        memWData_i = wdat;
        wData_i    = wd;
        wReg_i     = wre;
        wRegAddr_i = wra;
        for (int c = 0; c < len; c++) begin
            busRData_i = 16'($urandom);
            if (acc && k != 0 && c == k) begin
                busAck_i   = 1'b1;
                busRData_i = rdv;
            end else if (c == 0) begin
                busAck_i = 1'($urandom_range(0, 1));
            end else if (acc && c == len - 1) begin
                busAck_i = 1'b1;
            end else begin
                busAck_i = 1'b0;
            end
            @(negedge clk);
            done    = acc && (c == len - 1);
            stall_e = acc && (c < len - 1);
            req_e   = acc && (c >= 1) && (c <= len - 2);
            chk("stallReq", 32'(stallReq_o), 32'(stall_e));
            chk("busReq", 32'(busReq_o), 32'(req_e));
            if (req_e) begin
                chk("busWe", 32'(busWe_o), 32'(wr));
                chk("busAddr", 32'(busAddr_o), 32'(addr));
                chk("busWData", 32'(busWData_o), 32'(wdat));
            end
            chk("wReg", 32'(wReg_o), 32'(stall_e ? 1'b0 : (done ? (wre & ~err) : wre)));
            chk("wData", 32'(wData_o), 32'((done && readop) ? rdata_m : wd));
            chk("memErr", 32'(memErr_o), 32'(done && err));
            chk("wRegAddr", 32'(wRegAddr_o), 32'(wra));
            if (acc && readop && k != 0 && c == k) rdata_m = rdv;
            @(posedge clk);
            #1;
        end
        busAck_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        memRead_i = 0; memWrite_i = 0; memAddr_i = 0; memWData_i = 0;
        wData_i = 16'hA5A5; wReg_i = 1'b1; wRegAddr_i = 4'd7;
        busRData_i = 0; busAck_i = 0;
        rdata_m = 16'h0000;
        #2;
        chk("rst_busReq", 32'(busReq_o), 0);
        chk("rst_busWe", 32'(busWe_o), 0);
        chk("rst_busAddr", 32'(busAddr_o), 0);
        chk("rst_busWData", 32'(busWData_o), 0);
        chk("rst_memErr", 32'(memErr_o), 0);
        chk("rst_stall", 32'(stallReq_o), 0);
        chk("rst_wData", 32'(wData_o), 32'h0000A5A5);
        chk("rst_wReg", 32'(wReg_o), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pass-through
        run_instr(0, 0, 16'h0000, 16'h0000, 16'h1234, 1, 4'd3, 0, 16'h0);
        // Load acked in 2nd WAIT cycle
        run_instr(1, 0, 16'h0042, 16'h0000, 16'h1111, 1, 4'd5, 2, 16'hBEEF);
        // Store acked in 1st WAIT cycle
        run_instr(0, 1, 16'h00F0, 16'h55AA, 16'h2222, 1, 4'd6, 1, 16'h0);
        // Load timing out, ack arriving in DONE
        run_instr(1, 0, 16'h0100, 16'h0000, 16'h3333, 1, 4'd2, 0, 16'h0);
        // Ack on the last permitted WAIT cycle
        run_instr(1, 0, 16'h0102, 16'h0000, 16'h4444, 1, 4'd1, TO, 16'hC0DE);

        // Reset in the middle of WAIT
        memRead_i = 1; memWrite_i = 0; memAddr_i = 16'h0200; wReg_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        memRead_i = 1'b0;
        #1;
        chk("midrst_busReq", 32'(busReq_o), 0);
        chk("midrst_stall", 32'(stallReq_o), 0);
        chk("midrst_busAddr", 32'(busAddr_o), 0);
        chk("midrst_memErr", 32'(memErr_o), 0);
        rdata_m = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_instr(1, 0, 16'h0204, 16'h0000, 16'h5555, 1, 4'd9, 1, 16'h1357);

        // Read+write together, then back-to-back load
        run_instr(1, 1, 16'h0300, 16'h9ABC, 16'h6666, 1, 4'd10, 2, 16'hDEAD);
        run_instr(1, 0, 16'h0302, 16'h0000, 16'h7777, 1, 4'd11, 3, 16'h2468);

        // Random instruction mix
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_instr(kind[0], kind[1], 16'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, TO),
                      16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Parametrised MEM stage for the THCO-MIPS pipeline. It forwards EX/MEM write-back data and control to MEM/WB, and runs load/store instructions as request/acknowledge transactions on the data-memory bus. While a transaction is pending it requests a pipeline stall, and an access that never completes ends through a timeout with an error flag.

## Interface
- DATA_W, 16: data and bus data width.
- ADDR_W, 16: memory address width.
- REG_ADDR_W, 4: register-file address width.
- TIMEOUT, 15: maximum number of WAIT cycles without busAck_i before the access is aborted; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- memRead_i  in  1  instruction is a load.
- memWrite_i  in  1  instruction is a store; has priority when asserted together with memRead_i.
- memAddr_i  in  ADDR_W  access address.
- memWData_i  in  DATA_W  store data.
- wData_i  in  DATA_W  ALU result for write-back.
- wReg_i  in  1  register write enable.
- wRegAddr_i  in  REG_ADDR_W  destination register.
- busReq_o  out  1  bus request, registered.
- busWe_o  out  1  1 = write transaction, registered.
- busAddr_o  out  ADDR_W  registered address.
- busWData_o  out  DATA_W  registered write data.
- busRData_i  in  DATA_W  read data; sampled only in a cycle where busAck_i = 1.
- busAck_i  in  1  single-cycle completion pulse.
- wData_o  out  DATA_W  write-back data.
- wReg_o  out  1  write-back enable.
- wRegAddr_o  out  REG_ADDR_W  equal to wRegAddr_i at all times.
- stallReq_o  out  1  combinational request to freeze IF through MEM.
- memErr_o  out  1  one-cycle pulse, asserted in DONE after a timeout.

## Operation
- Access condition: acc = memRead_i | memWrite_i.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, acc = 0:
  - pure pass-through: wData_o = wData_i, wReg_o = wReg_i;
  - stallReq_o = 0.
- IDLE, acc = 1:
  - register busAddr_o = memAddr_i, busWData_o = memWData_i, busWe_o = memWrite_i;
  - set busReq_o = 1;
  - clear the timeout counter;
  - go to WAIT.
- WAIT:
  - busReq_o and all bus outputs are held stable.
  - On busAck_i = 1:
    - capture busRData_i into rdata when busWe_o = 0;
    - clear busReq_o;
    - go to DONE with err = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT:
    - clear busReq_o;
    - set err = 1;
    - go to DONE.
- DONE:
  - stallReq_o = 0, so the pipeline advances at the end of this cycle;
  - go to IDLE unconditionally;
  - an access presented in the following cycle is a new instruction.
- stallReq_o = (IDLE & acc) | WAIT.
- wReg_o:
  - 0 whenever stallReq_o = 1, so that only bubbles reach WB;
  - in DONE, wReg_o = wReg_i & ~err.
- wData_o:
  - in DONE after a read: rdata;
  - in every other case: wData_i.
- memErr_o = DONE & err.
- Read and write asserted together: performed as a write; wReg_o follows the DONE rule above.
- busAck_i outside WAIT is ignored. It must not change state or rdata.

## Timing
- Reset (asynchronous, immediate) clears:
  - FSM to IDLE;
  - busReq_o, busWe_o, busAddr_o, busWData_o to 0;
  - rdata, counter and err to 0.
- Consequence: memErr_o = 0. A reset in the middle of an access drops busReq_o in the same instant without waiting for a clock edge.
- The combinational outputs reflect their inputs during reset.
- Minimum access: 3 cycles, IDLE → WAIT (ack in the first WAIT cycle) → DONE. stallReq_o is high for 2 cycles.
- An access acknowledged in the k-th WAIT cycle takes k+2 cycles in total.
- Timeout access: 1 IDLE cycle, TIMEOUT WAIT cycles, then 1 DONE cycle.
- busReq_o rises one edge after entry to IDLE-with-acc and falls on the edge at which WAIT exits.
- Non-access instructions have zero added latency.
- Back-to-back accesses: DONE → IDLE → WAIT. busReq_o is low for at least 2 cycles between transactions.

## Test plan
- Pass-through: acc = 0, wData_i = 16'h1234, wReg_i = 1, wRegAddr_i = 3 → same values on the outputs in the same cycle; stallReq_o = 0; busReq_o stays 0.
- Load, ack on the 2nd WAIT cycle with busRData_i = 16'hBEEF → stallReq_o high for 3 cycles; in DONE, wData_o = 16'hBEEF and wReg_o = 1; busAddr_o equals memAddr_i throughout.
- Store to 16'h00F0 with data 16'h55AA, ack on the 1st WAIT cycle → busWe_o = 1 and busWData_o = 16'h55AA while busReq_o is high; in DONE, wData_o = wData_i.
- Timeout with TIMEOUT = 4 and no ack → busReq_o high for exactly 4 cycles; memErr_o = 1 and wReg_o = 0 in DONE; an ack arriving in DONE is ignored.
- Reset asserted mid-WAIT → busReq_o and stallReq_o fall immediately; after release the next load completes normally.
- Read and write both asserted, followed by a back-to-back load → a write transaction is issued; the second request starts only after DONE and IDLE, with rdata from the second access.
